// File: rtl/xpu_vpu_pc_tn_vlsu_st_rf_pipe_if.sv
// Store uop input bus between the VRF read port and the VLSU store RF stage.
// master: VRF side (drives vld/info/srcv_data, receives rdy)
// slave : RF stage (receives vld/info/srcv_data, drives rdy)
interface xpu_vpu_pc_tn_vlsu_st_rf_pipe_if #(
    parameter int unsigned LANE_VLEN = 128,
    parameter int unsigned NUM_SRCV  = 4,
    parameter int unsigned INFO_W    = 852
);
    logic                          vrf_vlsu_st_vld;
    logic [INFO_W-1:0]             vrf_vlsu_st_info;
    logic [NUM_SRCV*LANE_VLEN-1:0] vrf_vlsu_st_srcv_data;
    logic                          vlsu_vrf_st_rdy;

    modport master (
        output vrf_vlsu_st_vld,
        output vrf_vlsu_st_info,
        output vrf_vlsu_st_srcv_data,
        input  vlsu_vrf_st_rdy
    );

    modport slave (
        input  vrf_vlsu_st_vld,
        input  vrf_vlsu_st_info,
        input  vrf_vlsu_st_srcv_data,
        output vlsu_vrf_st_rdy
    );
endinterface

// File: rtl/xpu_vpu_pc_tn_vlsu_st_rf_pipe.sv
// VLSU store RF stage: decodes incoming store uops, drops fully-masked uops
// with a skip pulse, and buffers the rest in a DEPTH-entry in-order FIFO.
// Ports: forever_cpuclk/cpurst_b (clock, sync active-low reset), st_if (uop
// input bus, slave), rtu_vpu_flush (kill all), vlsu_st_uop_rdy (downstream
// ready), vrf_vlsu_st_uop_* (decoded head entry), vlsu_st_uop_skip_* (skip
// completion pulse), vlsu_st_rf_entry_cnt (occupancy).

`ifndef XPU_VPU_PC_TN_VIS_FUNC
`define XPU_VPU_PC_TN_VIS_FUNC      851
`define XPU_VPU_PC_TN_VIS_SRC1      829
`define XPU_VPU_PC_TN_VIS_SRCVM     765
`define XPU_VPU_PC_TN_VIS_VSEW      749
`define XPU_VPU_PC_TN_VIS_ELE_VIMM  747
`define XPU_VPU_PC_TN_VIS_ELE_LEN   742
`define XPU_VPU_PC_TN_VIS_VSTART_LEN 737
`define XPU_VPU_PC_TN_VIS_OP_LAST   732
`endif

module xpu_vpu_pc_tn_vlsu_st_rf_pipe #(
    parameter int unsigned LANE_VLEN = 128,
    parameter int unsigned NUM_SRCV  = 4,
    parameter int unsigned UID_W     = 8,
    parameter int unsigned INFO_W    = 852,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                          forever_cpuclk,
    input  logic                          cpurst_b,
    xpu_vpu_pc_tn_vlsu_st_rf_pipe_if.slave st_if,
    input  logic                          rtu_vpu_flush,
    input  logic                          vlsu_st_uop_rdy,
    output logic                          vrf_vlsu_st_uop_vld,
    output logic [UID_W-1:0]              vrf_vlsu_st_uop_uid,
    output logic [2:0]                    vrf_vlsu_st_uop_type,
    output logic [1:0]                    vrf_vlsu_st_uop_eew,
    output logic [1:0]                    vrf_vlsu_st_uop_mew,
    output logic [1:0]                    vrf_vlsu_st_uop_nf,
    output logic                          vrf_vlsu_st_uop_vm,
    output logic                          vrf_vlsu_st_uop_crt_idx_shift,
    output logic                          vrf_vlsu_st_uop_lmul_mode,
    output logic                          vrf_vlsu_st_uop_fast_cmplt,
    output logic                          vrf_vlsu_st_uop_dbg_pc_vld,
    output logic [2:0]                    vrf_vlsu_st_uop_dbg_pc,
    output logic                          vrf_vlsu_st_uop_op_last,
    output logic [4:0]                    vrf_vlsu_st_uop_ele_len,
    output logic [4:0]                    vrf_vlsu_st_uop_ele_vimm,
    output logic [4:0]                    vrf_vlsu_st_uop_vstart_len,
    output logic [3:0]                    vrf_vlsu_st_uop_vidx_start,
    output logic [3:0]                    vrf_vlsu_st_uop_vmask_start,
    output logic [LANE_VLEN/8-1:0]        vrf_vlsu_st_uop_vmask_data,
    output logic [NUM_SRCV*LANE_VLEN-1:0] vrf_vlsu_st_uop_srcv_data,
    output logic                          vlsu_st_uop_skip_vld,
    output logic [UID_W-1:0]              vlsu_st_uop_skip_uid,
    output logic [CNT_W-1:0]              vlsu_st_rf_entry_cnt
);
    localparam int unsigned ENUM       = LANE_VLEN / 8;
    localparam int unsigned SRCV_W     = NUM_SRCV * LANE_VLEN;
    localparam int unsigned PTR_W      = $clog2(DEPTH);
    localparam int unsigned FUNC_LSB   = `XPU_VPU_PC_TN_VIS_FUNC - 21;
    localparam int unsigned SRC1_LSB   = `XPU_VPU_PC_TN_VIS_SRC1 - 63;
    localparam int unsigned VMASK_LSB  = `XPU_VPU_PC_TN_VIS_SRCVM - (ENUM - 1);
    localparam int unsigned MEW_LSB    = `XPU_VPU_PC_TN_VIS_VSEW - 1;
    localparam int unsigned VIMM_LSB   = `XPU_VPU_PC_TN_VIS_ELE_VIMM - 4;
    localparam int unsigned ELEN_LSB   = `XPU_VPU_PC_TN_VIS_ELE_LEN - 4;
    localparam int unsigned VSTART_LSB = `XPU_VPU_PC_TN_VIS_VSTART_LEN - 4;
    localparam int unsigned OP_LAST_B  = `XPU_VPU_PC_TN_VIS_OP_LAST;

    typedef struct packed {
        logic [UID_W-1:0]  uid;
        logic [2:0]        uop_type;
        logic [1:0]        eew;
        logic [1:0]        mew;
        logic [1:0]        nf;
        logic              vm;
        logic              crt_idx_shift;
        logic              lmul_mode;
        logic              fast_cmplt;
        logic              dbg_pc_vld;
        logic [2:0]        dbg_pc;
        logic              op_last;
        logic [4:0]        ele_len;
        logic [4:0]        ele_vimm;
        logic [4:0]        vstart_len;
        logic [3:0]        vidx_start;
        logic [3:0]        vmask_start;
        logic [ENUM-1:0]   vmask_data;
        logic [SRCV_W-1:0] srcv_data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             skip_vld_q, skip_vld_d;
    logic [UID_W-1:0] skip_uid_q, skip_uid_d;

    entry_t in_e;
    entry_t head;
    logic   skip_c;
    logic   acc, push, pop, not_empty;
    logic   unused_info;

    // Only selected info bits are decoded; fold the bus to mark the rest used.
    assign unused_info = ^st_if.vrf_vlsu_st_info;

    // Decode the incoming uop into its stored fields.
    always_comb begin
        in_e               = '0;
        in_e.uid           = st_if.vrf_vlsu_st_info[UID_W-1:0];
        in_e.eew           = st_if.vrf_vlsu_st_info[FUNC_LSB +: 2];
        in_e.uop_type      = st_if.vrf_vlsu_st_info[FUNC_LSB + 2 +: 3];
        in_e.nf            = st_if.vrf_vlsu_st_info[FUNC_LSB + 5 +: 2];
        in_e.crt_idx_shift = st_if.vrf_vlsu_st_info[FUNC_LSB + 8];
        in_e.lmul_mode     = st_if.vrf_vlsu_st_info[FUNC_LSB + 9];
        in_e.fast_cmplt    = st_if.vrf_vlsu_st_info[FUNC_LSB + 11];
        in_e.dbg_pc_vld    = st_if.vrf_vlsu_st_info[FUNC_LSB + 12];
        in_e.dbg_pc        = st_if.vrf_vlsu_st_info[FUNC_LSB + 13 +: 3];
        in_e.vm            = st_if.vrf_vlsu_st_info[FUNC_LSB + 21];
        in_e.mew           = st_if.vrf_vlsu_st_info[MEW_LSB +: 2];
        in_e.vidx_start    = st_if.vrf_vlsu_st_info[SRC1_LSB +: 4];
        in_e.vmask_start   = st_if.vrf_vlsu_st_info[SRC1_LSB + 4 +: 4];
        in_e.vmask_data    = st_if.vrf_vlsu_st_info[VMASK_LSB +: ENUM];
        in_e.ele_vimm      = st_if.vrf_vlsu_st_info[VIMM_LSB +: 5];
        in_e.ele_len       = st_if.vrf_vlsu_st_info[ELEN_LSB +: 5];
        in_e.vstart_len    = st_if.vrf_vlsu_st_info[VSTART_LSB +: 5];
        in_e.op_last       = st_if.vrf_vlsu_st_info[OP_LAST_B];
        in_e.srcv_data     = st_if.vrf_vlsu_st_srcv_data;
    end

    // Fully-masked, non-last, non-fast uops complete without entering the buffer.
    assign skip_c    = ~in_e.vm & (in_e.vmask_data == '0) & ~in_e.op_last & ~in_e.fast_cmplt;
    assign not_empty = (count_q != '0);
    assign acc       = st_if.vrf_vlsu_st_vld & st_if.vlsu_vrf_st_rdy;
    assign push      = acc & ~skip_c & ~rtu_vpu_flush;
    assign pop       = not_empty & vlsu_st_uop_rdy & ~rtu_vpu_flush;

    // Accept depends on registered occupancy only.
    assign st_if.vlsu_vrf_st_rdy = (count_q != CNT_W'(DEPTH));

    // Next-state: FIFO pointers, occupancy, skip pulse, flush.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        skip_vld_d = 1'b0;
        skip_uid_d = skip_uid_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_e;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (acc & skip_c & ~rtu_vpu_flush) begin
            skip_vld_d = 1'b1;
            skip_uid_d = in_e.uid;
        end
        if (rtu_vpu_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            skip_vld_d = 1'b0;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            skip_vld_q <= 1'b0;
            skip_uid_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            skip_vld_q <= skip_vld_d;
            skip_uid_q <= skip_uid_d;
        end
    end

    // Payload storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge forever_cpuclk) begin
        mem_q <= mem_d;
    end

    // Head entry, forced to zero when empty.
    always_comb begin
        head = '0;
        if (not_empty) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign vrf_vlsu_st_uop_vld           = not_empty;
    assign vrf_vlsu_st_uop_uid           = head.uid;
    assign vrf_vlsu_st_uop_type          = head.uop_type;
    assign vrf_vlsu_st_uop_eew           = head.eew;
    assign vrf_vlsu_st_uop_mew           = head.mew;
    assign vrf_vlsu_st_uop_nf            = head.nf;
    assign vrf_vlsu_st_uop_vm            = head.vm;
    assign vrf_vlsu_st_uop_crt_idx_shift = head.crt_idx_shift;
    assign vrf_vlsu_st_uop_lmul_mode     = head.lmul_mode;
    assign vrf_vlsu_st_uop_fast_cmplt    = head.fast_cmplt;
    assign vrf_vlsu_st_uop_dbg_pc_vld    = head.dbg_pc_vld;
    assign vrf_vlsu_st_uop_dbg_pc        = head.dbg_pc;
    assign vrf_vlsu_st_uop_op_last       = head.op_last;
    assign vrf_vlsu_st_uop_ele_len       = head.ele_len;
    assign vrf_vlsu_st_uop_ele_vimm      = head.ele_vimm;
    assign vrf_vlsu_st_uop_vstart_len    = head.vstart_len;
    assign vrf_vlsu_st_uop_vidx_start    = head.vidx_start;
    assign vrf_vlsu_st_uop_vmask_start   = head.vmask_start;
    assign vrf_vlsu_st_uop_vmask_data    = head.vmask_data;
    assign vrf_vlsu_st_uop_srcv_data     = head.srcv_data;
    assign vlsu_st_uop_skip_vld          = skip_vld_q;
    assign vlsu_st_uop_skip_uid          = skip_uid_q;
    assign vlsu_st_rf_entry_cnt          = count_q;
endmodule

// File: tb/tb_xpu_vpu_pc_tn_vlsu_st_rf_pipe.sv
// Directed bench for the VLSU store RF stage (DEPTH=2).
module tb_xpu_vpu_pc_tn_vlsu_st_rf_pipe;
    localparam int unsigned LANE_VLEN = 128;
    localparam int unsigned NUM_SRCV  = 4;
    localparam int unsigned UID_W     = 8;
    localparam int unsigned INFO_W    = 852;
    localparam int unsigned DEPTH     = 2;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned ENUM      = LANE_VLEN / 8;
    localparam int unsigned SRCV_W    = NUM_SRCV * LANE_VLEN;
    // Info field offsets (MSB of each field)
    localparam int unsigned F_FUNC    = 851;
    localparam int unsigned F_SRC1    = 829;
    localparam int unsigned F_SRCVM   = 765;
    localparam int unsigned F_OP_LAST = 732;

    logic clk;
    logic rst_b;
    logic flush;
    logic uop_rdy;
    logic o_vld, o_vm, o_cis, o_lmul, o_fast, o_dpv, o_last, o_skip_vld;
    logic [UID_W-1:0] o_uid, o_skip_uid;
    logic [2:0] o_type, o_dpc;
    logic [1:0] o_eew, o_mew, o_nf;
    logic [4:0] o_elen, o_evimm, o_vstart;
    logic [3:0] o_vidx, o_vmstart;
    logic [ENUM-1:0] o_vmask;
    logic [SRCV_W-1:0] o_srcv;
    logic [CNT_W-1:0] o_cnt;

    int tests;
    int fails;

    xpu_vpu_pc_tn_vlsu_st_rf_pipe_if #(
        .LANE_VLEN(LANE_VLEN), .NUM_SRCV(NUM_SRCV), .INFO_W(INFO_W)
    ) st_if ();

    xpu_vpu_pc_tn_vlsu_st_rf_pipe #(
        .LANE_VLEN(LANE_VLEN), .NUM_SRCV(NUM_SRCV), .UID_W(UID_W),
        .INFO_W(INFO_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .forever_cpuclk               (clk),
        .cpurst_b                     (rst_b),
        .st_if                        (st_if.slave),
        .rtu_vpu_flush                (flush),
        .vlsu_st_uop_rdy              (uop_rdy),
        .vrf_vlsu_st_uop_vld          (o_vld),
        .vrf_vlsu_st_uop_uid          (o_uid),
        .vrf_vlsu_st_uop_type         (o_type),
        .vrf_vlsu_st_uop_eew          (o_eew),
        .vrf_vlsu_st_uop_mew          (o_mew),
        .vrf_vlsu_st_uop_nf           (o_nf),
        .vrf_vlsu_st_uop_vm           (o_vm),
        .vrf_vlsu_st_uop_crt_idx_shift(o_cis),
        .vrf_vlsu_st_uop_lmul_mode    (o_lmul),
        .vrf_vlsu_st_uop_fast_cmplt   (o_fast),
        .vrf_vlsu_st_uop_dbg_pc_vld   (o_dpv),
        .vrf_vlsu_st_uop_dbg_pc       (o_dpc),
        .vrf_vlsu_st_uop_op_last      (o_last),
        .vrf_vlsu_st_uop_ele_len      (o_elen),
        .vrf_vlsu_st_uop_ele_vimm     (o_evimm),
        .vrf_vlsu_st_uop_vstart_len   (o_vstart),
        .vrf_vlsu_st_uop_vidx_start   (o_vidx),
        .vrf_vlsu_st_uop_vmask_start  (o_vmstart),
        .vrf_vlsu_st_uop_vmask_data   (o_vmask),
        .vrf_vlsu_st_uop_srcv_data    (o_srcv),
        .vlsu_st_uop_skip_vld         (o_skip_vld),
        .vlsu_st_uop_skip_uid         (o_skip_uid),
        .vlsu_st_rf_entry_cnt         (o_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [INFO_W-1:0] make_info(input logic [7:0] uid, input logic [21:0] func,
                                                    input logic [15:0] vmask, input logic op_last);
        logic [INFO_W-1:0] r;
        r = '0;
        r[7:0] = uid;
        r[F_FUNC -: 22] = func;
        r[F_SRC1 -: 64] = 64'h5A;
        r[F_SRCVM -: 16] = vmask;
        r[F_OP_LAST] = op_last;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [7:0] uid, input logic [21:0] func,
                         input logic [15:0] vmask, input logic op_last);
        st_if.vrf_vlsu_st_vld  = v;
        st_if.vrf_vlsu_st_info = make_info(uid, func, vmask, op_last);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [SRCV_W-1:0] srcv_a5;
        int sent;
        int got;
        logic did_pop;
        logic did_push;
        tests = 0;
        fails = 0;
        clk = 1'b0;
        rst_b = 1'b0;
        flush = 1'b0;
        uop_rdy = 1'b0;
        srcv_a5 = '0;
        srcv_a5[127:0] = {16{8'hA5}};
        st_if.vrf_vlsu_st_srcv_data = '0;
        drive(1'b0, 8'h00, 22'h0, 16'h0, 1'b0);

        // Reset
        step();
        step();
        chk("rst_cnt", o_cnt, 0);
        chk("rst_vld", o_vld, 0);
        chk("rst_uid", o_uid, 0);
        chk("rst_skip", o_skip_vld, 0);
        chk("rst_skip_uid", o_skip_uid, 0);
        chk("rst_rdy", st_if.vlsu_vrf_st_rdy, 1);
        rst_b = 1'b1;
        step();

        // Single uop through an empty buffer
        uop_rdy = 1'b1;
        st_if.vrf_vlsu_st_srcv_data = srcv_a5;
        drive(1'b1, 8'h3A, 22'h200815, 16'h0, 1'b0);
        step();
        drive(1'b0, 8'h00, 22'h0, 16'h0, 1'b0);
        st_if.vrf_vlsu_st_srcv_data = '0;
        chk("t1_vld", o_vld, 1);
        chk("t1_uid", o_uid, 8'h3A);
        chk("t1_eew", o_eew, 1);
        chk("t1_type", o_type, 5);
        chk("t1_nf", o_nf, 0);
        chk("t1_vm", o_vm, 1);
        chk("t1_fast", o_fast, 1);
        chk("t1_vidx", o_vidx, 4'hA);
        chk("t1_vmstart", o_vmstart, 4'h5);
        chk("t1_srcv", o_srcv, srcv_a5);
        step();
        chk("t1_vld_n2", o_vld, 0);
        chk("t1_cnt_n2", o_cnt, 0);

        // Back-pressure and fill
        uop_rdy = 1'b0;
        drive(1'b1, 8'h01, 22'h200000, 16'h0, 1'b0);
        step();
        chk("bp_cnt1", o_cnt, 1);
        drive(1'b1, 8'h02, 22'h200000, 16'h0, 1'b0);
        step();
        chk("bp_cnt2", o_cnt, 2);
        chk("bp_rdy_full", st_if.vlsu_vrf_st_rdy, 0);
        drive(1'b1, 8'h03, 22'h200000, 16'h0, 1'b0);
        step();
        chk("bp_cnt_hold", o_cnt, 2);
        chk("bp_head1", o_uid, 8'h01);
        uop_rdy = 1'b1;
        step();
        chk("bp_head2", o_uid, 8'h02);
        chk("bp_cnt_pop", o_cnt, 1);
        chk("bp_rdy_back", st_if.vlsu_vrf_st_rdy, 1);
        step();
        drive(1'b0, 8'h00, 22'h0, 16'h0, 1'b0);
        chk("bp_head3", o_uid, 8'h03);
        chk("bp_cnt_3", o_cnt, 1);
        step();
        chk("bp_drained", o_vld, 0);

        // Skip
        uop_rdy = 1'b0;
        drive(1'b1, 8'h20, 22'h200000, 16'h0, 1'b0);
        step();
        drive(1'b1, 8'h11, 22'h000000, 16'h0, 1'b0);
        step();
        chk("sk_vld", o_skip_vld, 1);
        chk("sk_uid", o_skip_uid, 8'h11);
        chk("sk_cnt", o_cnt, 1);
        drive(1'b1, 8'h12, 22'h000000, 16'h0, 1'b1);
        step();
        drive(1'b0, 8'h00, 22'h0, 16'h0, 1'b0);
        chk("sk_pulse_end", o_skip_vld, 0);
        chk("sk_oplast_cnt", o_cnt, 2);
        chk("sk_head", o_uid, 8'h20);

        // Flush with 2 entries while a pop and a new uop are presented
        uop_rdy = 1'b1;
        flush = 1'b1;
        drive(1'b1, 8'h33, 22'h200000, 16'h0, 1'b0);
        step();
        chk("fl_cnt", o_cnt, 0);
        chk("fl_vld", o_vld, 0);
        chk("fl_skip", o_skip_vld, 0);
        chk("fl_rdy", st_if.vlsu_vrf_st_rdy, 1);
        // Flush while a skippable uop is accepted: no pulse, nothing stored
        drive(1'b1, 8'h44, 22'h000000, 16'h0, 1'b0);
        step();
        chk("fl2_skip", o_skip_vld, 0);
        chk("fl2_cnt", o_cnt, 0);
        flush = 1'b0;
        drive(1'b0, 8'h00, 22'h0, 16'h0, 1'b0);
        step();

        // Wrap-around stream with random downstream ready
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
            uop_rdy = 1'($urandom_range(0, 1));
            if (sent < 10) drive(1'b1, 8'(8'h50 + sent), 22'h200000, 16'h0, 1'b0);
            else drive(1'b0, 8'h00, 22'h0, 16'h0, 1'b0);
            #1;
            did_pop = o_vld & uop_rdy;
            did_push = st_if.vrf_vlsu_st_vld & st_if.vlsu_vrf_st_rdy;
            if (did_pop) begin
                chk("wrap_uid", o_uid, 8'(8'h50 + got));
                got++;
            end
            if (did_push) sent++;
            step();
        end
        drive(1'b0, 8'h00, 22'h0, 16'h0, 1'b0);
        chk("wrap_count", got, 10);

        // Reset mid-operation
        uop_rdy = 1'b0;
        drive(1'b1, 8'h61, 22'h200000, 16'h0, 1'b0);
        step();
        drive(1'b1, 8'h62, 22'h200000, 16'h0, 1'b0);
        step();
        drive(1'b0, 8'h00, 22'h0, 16'h0, 1'b0);
        chk("mr_cnt_pre", o_cnt, 2);
        rst_b = 1'b0;
        step();
        chk("mr_cnt", o_cnt, 0);
        chk("mr_vld", o_vld, 0);
        chk("mr_uid", o_uid, 0);
        chk("mr_srcv", o_srcv, 0);
        chk("mr_skip_uid", o_skip_uid, 0);
        chk("mr_rdy", st_if.vlsu_vrf_st_rdy, 1);
        rst_b = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
